// File: rtl/rk16_pkg.sv
// Shared RK16 front-end definitions: datapath widths and the ifetch state type.
package rk16_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned IMEM_AW = 17;
    localparam int unsigned PC_W    = 16;
    localparam int unsigned HALF_W  = 16;
    localparam int unsigned WDT_W   = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_LO = 3'd1,
        FETCH_HI = 3'd2,
        FULL     = 3'd3,
        STEP     = 3'd4
    } ifetch_state_t;

endpackage

// File: rtl/ifetch_wdt.sv
// Memory wait watchdog: counts consecutive unacknowledged request cycles and
// raises a sticky error once TIMEOUT of them have elapsed.
//   clk, rst  : clock, synchronous active-high reset
//   active    : a request is outstanding and unacked this cycle
//   clear     : abandon the current wait (redirect)
//   err       : sticky timeout flag, cleared only by rst
//   expire_c  : combinational pulse in the cycle the limit is reached
module ifetch_wdt
    import rk16_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic clear,
    output logic err,
    output logic expire_c
);

    logic [WDT_W-1:0] cnt;

    // The TIMEOUT-th consecutive unacked cycle is the one that expires.
    assign expire_c = active && !clear && (cnt == WDT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (clear || !active) begin
            cnt <= '0;
        end else if (expire_c) begin
            cnt <= '0;
            err <= 1'b1;
        end else begin
            cnt <= cnt + WDT_W'(1);
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: reads two halfwords from imem at {pc,0} and {pc,1},
// presents {hi,lo} to decode over a valid/ready handshake, then pulses
// pc_step once so the pfc advances.
//   clk, rst              : clock, synchronous active-high reset
//   pc / pc_step          : program counter in, one-cycle advance out
//   flush                 : redirect, drops in-flight and held instruction
//   mem_req/addr/ack/rdata: imem read port (ack may come in request cycle)
//   ir/ir_pc/ir_valid/ir_ready : instruction to decode
//   fetch_err             : sticky memory timeout flag
module ifetch
    import rk16_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    pc,
    output logic               pc_step,
    input  logic               flush,
    output logic               mem_req,
    output logic [IMEM_AW-1:0] mem_addr,
    input  logic               mem_ack,
    input  logic [HALF_W-1:0]  mem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic [PC_W-1:0]    ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic               fetch_err
);

    ifetch_state_t      state;
    ifetch_state_t      state_nx;
    logic [HALF_W-1:0]  lo;
    logic [PC_W-1:0]    fetch_pc;
    logic [IMEM_AW-1:0] addr_hold;
    logic               wdt_active;
    logic               wdt_expire;
    logic               ack_lo;
    logic               ack_hi;
    logic               handshake;

    // Kept separate from the next-state block so the watchdog path has no
    // combinational dependence on that block's outputs.
    assign wdt_active = ((state == FETCH_LO) || (state == FETCH_HI)) && !mem_ack;

    ifetch_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk      (clk),
        .rst      (rst),
        .active   (wdt_active),
        .clear    (flush),
        .err      (fetch_err),
        .expire_c (wdt_expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and memory-side outputs; address is live during the request
    // so a same-cycle ack can complete each halfword in one cycle.
    always_comb begin
        state_nx  = state;
        mem_req   = 1'b0;
        mem_addr  = addr_hold;
        pc_step   = 1'b0;
        ack_lo    = 1'b0;
        ack_hi    = 1'b0;
        handshake = 1'b0;
        case (state)
            IDLE: state_nx = FETCH_LO;
            FETCH_LO: begin
                mem_req  = 1'b1;
                mem_addr = {pc, 1'b0};
                if (flush) begin
                    state_nx = FETCH_LO;
                end else if (mem_ack) begin
                    ack_lo   = 1'b1;
                    state_nx = FETCH_HI;
                end
            end
            FETCH_HI: begin
                mem_req  = 1'b1;
                mem_addr = {fetch_pc, 1'b1};
                if (flush || wdt_expire) begin
                    state_nx = FETCH_LO;
                end else if (mem_ack) begin
                    ack_hi   = 1'b1;
                    state_nx = FULL;
                end
            end
            FULL: begin
                if (flush) begin
                    state_nx = FETCH_LO;
                end else if (ir_ready) begin
                    handshake = 1'b1;
                    state_nx  = STEP;
                end
            end
            STEP: begin
                pc_step  = !flush;
                state_nx = FETCH_LO;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Halfword assembly, instruction register and address hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo        <= '0;
            fetch_pc  <= '0;
            ir        <= '0;
            ir_pc     <= '0;
            ir_valid  <= 1'b0;
            addr_hold <= '0;
        end else begin
            addr_hold <= mem_addr;
            if (flush && (state != IDLE)) begin
                lo       <= '0;
                ir_valid <= 1'b0;
            end else begin
                if (ack_lo) begin
                    lo       <= mem_rdata;
                    fetch_pc <= pc;
                end
                if (ack_hi) begin
                    ir       <= {mem_rdata, lo};
                    ir_pc    <= fetch_pc;
                    ir_valid <= 1'b1;
                end
                if (handshake) ir_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a progress-based model.
module tb_ifetch;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic        pc_step;
    logic        flush;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [31:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        fetch_err;

    int n_vec = 0;
    int n_bad = 0;

    ifetch #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .pc_step   (pc_step),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir        (ir),
        .ir_pc     (ir_pc),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks how many halfwords of the current instruction
    // have been collected, whether one is held for decode, and whether a pc
    // advance is owed.
    bit          m_ok = 0;
    bit          m_started;
    int          m_half;
    int          m_wait;
    logic [15:0] m_lo, m_fpc, m_irpc;
    logic [31:0] m_ir;
    logic        m_valid, m_step, m_err;
    logic [16:0] m_last;

    always @(negedge clk) begin : model_cmp
        bit          fetching;
        logic [16:0] e_addr;
        fetching = m_started && !m_valid && !m_step;
        if (!fetching)      e_addr = m_last;
        else if (m_half == 0) e_addr = {pc, 1'b0};
        else                e_addr = {m_fpc, 1'b1};

        if (m_ok) begin
            chk("mem_req",   32'(mem_req),   32'(fetching));
            chk("mem_addr",  32'(mem_addr),  32'(e_addr));
            chk("pc_step",   32'(pc_step),   32'(m_step && !flush));
            chk("ir_valid",  32'(ir_valid),  32'(m_valid));
            chk("fetch_err", 32'(fetch_err), 32'(m_err));
            chk("ir",        ir,             m_ir);
            chk("ir_pc",     32'(ir_pc),     32'(m_irpc));
        end

        m_last = e_addr;
        if (rst) begin
            m_ok = 1; m_started = 0; m_half = 0; m_wait = 0;
            m_lo = '0; m_fpc = '0; m_irpc = '0; m_ir = '0;
            m_valid = 0; m_step = 0; m_err = 0; m_last = '0;
        end else if (!m_started) begin
            m_started = 1;
        end else if (flush) begin
            m_half = 0; m_lo = '0; m_valid = 0; m_step = 0; m_wait = 0;
        end else if (m_step) begin
            m_step = 0;
        end else if (m_valid) begin
            if (ir_ready) begin
                m_valid = 0;
                m_step  = 1;
            end
        end else if (mem_ack) begin
            m_wait = 0;
            if (m_half == 0) begin
                m_lo = mem_rdata; m_fpc = pc; m_half = 1;
            end else begin
                m_ir = {mem_rdata, m_lo}; m_irpc = m_fpc; m_valid = 1; m_half = 0;
            end
        end else begin
            m_wait++;
            if (m_wait == int'(TMO)) begin
                m_err = 1; m_wait = 0; m_half = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; pc = '0; flush = 1'b0; mem_ack = 1'b0;
        mem_rdata = '0; ir_ready = 1'b0;
        tick(); tick();
        #1;
        chk("rst_ir",       ir,                32'h0);
        chk("rst_ir_valid", 32'(ir_valid),     32'h0);
        chk("rst_mem_req",  32'(mem_req),      32'h0);
        chk("rst_mem_addr", 32'(mem_addr),     32'h0);
        chk("rst_err",      32'(fetch_err),    32'h0);

        // Basic fetch with same-cycle acks.
        rst = 1'b0; pc = 16'h0010; mem_ack = 1'b1; mem_rdata = 16'h5678;
        tick(); #1;
        chk("lo_req",  32'(mem_req),  32'h1);
        chk("lo_addr", 32'(mem_addr), 32'h00020);
        tick(); mem_rdata = 16'h1234; #1;
        chk("hi_addr", 32'(mem_addr), 32'h00021);
        tick(); #1;
        chk("ir_word",  ir,            32'h12345678);
        chk("ir_pc",    32'(ir_pc),    32'h0010);
        chk("ir_valid", 32'(ir_valid), 32'h1);

        // Decode stalls for five cycles.
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            chk("hold_ir",   ir,            32'h12345678);
            chk("hold_step", 32'(pc_step),  32'h0);
            chk("hold_req",  32'(mem_req),  32'h0);
            chk("hold_addr", 32'(mem_addr), 32'h00021);
        end
        ir_ready = 1'b1;
        tick(); ir_ready = 1'b0; pc = 16'h0012; mem_rdata = 16'hbeef; #1;
        chk("step_pulse", 32'(pc_step),  32'h1);
        chk("step_valid", 32'(ir_valid), 32'h0);
        tick(); #1;
        chk("step_once", 32'(pc_step),  32'h0);
        chk("next_addr", 32'(mem_addr), 32'h00024);
        tick(); mem_rdata = 16'hcafe;
        tick(); #1;
        chk("ir_word2", ir, 32'hcafebeef);

        // Flush wins over a simultaneous handshake.
        flush = 1'b1; ir_ready = 1'b1; pc = 16'h1234; #1;
        chk("flush_hs_step", 32'(pc_step), 32'h0);
        tick(); flush = 1'b0; ir_ready = 1'b0; mem_rdata = 16'h1111; #1;
        chk("flush_nostep",  32'(pc_step),  32'h0);
        chk("flush_valid",   32'(ir_valid), 32'h0);
        chk("flush_addr",    32'(mem_addr), 32'h02468);

        // Flush in the step cycle.
        tick(); mem_rdata = 16'h2222;
        tick(); ir_ready = 1'b1;
        tick(); ir_ready = 1'b0; flush = 1'b1; pc = 16'h0100; #1;
        chk("step_flush", 32'(pc_step), 32'h0);
        tick(); flush = 1'b0; #1;
        chk("redir_req",  32'(mem_req),  32'h1);
        chk("redir_addr", 32'(mem_addr), 32'h00200);

        // Memory timeout, recovery at the top of the address space, reset.
        mem_ack = 1'b0; #1;
        chk("tmo_before", 32'(fetch_err), 32'h0);
        tick(); tick(); tick(); #1;
        chk("tmo_edge", 32'(fetch_err), 32'h0);
        tick(); #1;
        chk("tmo_err", 32'(fetch_err), 32'h1);
        chk("tmo_req", 32'(mem_req),   32'h1);
        pc = 16'hFFFF; mem_ack = 1'b1; mem_rdata = 16'haaaa; #1;
        chk("top_lo_addr", 32'(mem_addr), 32'h1FFFE);
        tick(); mem_rdata = 16'h5555; #1;
        chk("top_hi_addr", 32'(mem_addr), 32'h1FFFF);
        tick(); #1;
        chk("top_ir",     ir,             32'h5555aaaa);
        chk("top_ir_pc",  32'(ir_pc),     32'hFFFF);
        chk("err_sticky", 32'(fetch_err), 32'h1);
        rst = 1'b1;
        tick(); #1;
        chk("rst_clr_err",   32'(fetch_err), 32'h0);
        chk("rst_clr_valid", 32'(ir_valid),  32'h0);
        rst = 1'b0;

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            mem_ack   = ($urandom_range(0, 9) < 7);
            ir_ready  = 1'($urandom_range(0, 1));
            mem_rdata = 16'($urandom);
            if ($urandom_range(0, 3) == 0) pc = 16'($urandom);
        end
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
